xilinx_multi_port_bram: RTL and testbench
=========================================

# xilinx_multi_port_bram

Parametrised successor to the cache's dual-port BRAM. It provides one read/write port (A) with byte enables and `NUM_RD` independent read-only ports (B). Each read port has a selectable collision mode and an optional output register stage. A built-in clear engine zeroes the whole array after reset. Tag, state and data arrays in the cache use it wherever several pipeline stages must look up the same array in one cycle.

## Interface
- `RAM_WIDTH`, 18, data width in bits.
- `RAM_DEPTH`, 1024, entries; `AW = clogb2(RAM_DEPTH-1)`, minimum 1.
- `BYTE_WIDTH`, `RAM_WIDTH`, write-enable granularity; `NB = RAM_WIDTH/BYTE_WIDTH`. Non-integer ratio is an elaboration error.
- `NUM_RD`, 2, number of read-only ports, 1..4.
- `COLLIDE_WF`, 0, `NUM_RD`-bit mask; bit i=1 makes read port i write-first (bypass), 0 makes it read-first.
- `OUT_REG`, 1, 1 adds an output register stage on every read path, 0 omits it.
- `CLEAR_ON_RESET`, 1, 1 zeroes the array after reset.

Ports:
- `clock`, in, 1, sole clock.
- `resetn`, in, 1, reset; synchronous, active-low.
- `ready`, out, 1, high when user accesses are accepted.
- `ena`, in, 1, port A enable.
- `wea`, in, NB, port A byte write enables.
- `addra`, in, AW, port A address.
- `dina`, in, RAM_WIDTH, port A write data.
- `douta`, out, RAM_WIDTH, port A read data.
- `enb`, in, NUM_RD, per-port read enables.
- `addrb`, in, NUM_RD*AW, packed addresses; port i occupies bits `[i*AW +: AW]`.
- `doutb`, out, NUM_RD*RAM_WIDTH, packed read data.
- `validb`, out, NUM_RD, high when the corresponding `doutb` slice carries the data of a request.

## Operation
- FSM states:
  - CLEAR:
    - `ready`=0.
    - Writes 0 to address `clr_cnt` each cycle, with `clr_cnt` running 0..RAM_DEPTH-1.
    - User inputs are ignored and `validb` stays 0.
    - Moves to READY after the last address is written.
  - READY: `ready`=1; normal operation.
- `resetn` low:
  - FSM enters CLEAR (or READY if `CLEAR_ON_RESET`=0).
  - `clr_cnt` is set to 0.
  - All pipeline registers, `douta`, `doutb` and `validb` are set to 0.
  - Array contents are otherwise untouched.
- Port A write (`ena`=1, `wea`≠0): each byte k with `wea[k]`=1 is updated.
- Port A read (`ena`=1, `wea`=0): returns the array word.
- Port A on a write cycle is no-change: its read register holds its previous value.
- Port B read (`enb[i]`=1): returns the array word at `addrb` slice i.
- Collision, defined as the same-cycle port A write to the address read by port i:
  - Read-first: returns the pre-write word.
  - Write-first: returns the merged word. Enabled bytes come from `dina`; the other bytes come from the array.
- Reads with `enb[i]`=0 leave the read register of port i unchanged, and `validb[i]` drops to 0 with the same latency as data.
- Ports B never write.

## Timing
- Read latency from the request cycle T:
  - Data and `validb` appear at T+1 when `OUT_REG`=0.
  - They appear at T+2 when `OUT_REG`=1.
  - The same latency applies to `douta`.
- Write takes effect at the T+1 edge. A port A read or a read-first port B read in T+1 sees the new data.
- Full throughput: one request per port per cycle, with no bubbles.
- `ready` rises exactly RAM_DEPTH cycles after the first cycle with `resetn` high; it is already 1 in that first cycle when `CLEAR_ON_RESET`=0.
- Reset asserted mid-CLEAR: the clear restarts at address 0 and takes a full RAM_DEPTH cycles after release.
- Reset asserted mid-read: in-flight data is discarded and outputs read 0 the next cycle.
- Requests presented while `ready`=0 are dropped and never produce `validb`.

## Structure
- Shared package `xilinx_bram_pkg`: `clogb2` function, `RD_FIRST`/`WR_FIRST` constants, FSM state encoding.
- Sub-module `bram_clear_fsm`:
  - Contains the counter and state.
  - Outputs `ready`, `clr_we` and `clr_addr`.
  - A mux in the top level selects these over port A during CLEAR.
- Each read port is generated by a loop; bypass merge logic is per port and per byte.

## Test plan
- Clear after reset (DEPTH=16, `CLEAR_ON_RESET`=1): array preloaded with 0xFF..; release reset → `ready` high after exactly 16 cycles; a port B read of addr 5 returns 0.
- Basic latency (`OUT_REG`=1): write 0x2A5 to addr 3, read addr 3 on port B0 next cycle → `doutb`[0]=0x2A5 and `validb`[0]=1 two cycles after the read.
- Collision (`COLLIDE_WF`=2'b10): addr 7 holds 0x111; same cycle write 0x222 to addr 7, B0 and B1 read addr 7 → B0 returns 0x111, B1 returns 0x222.
- Byte enables (WIDTH=16, BYTE=8): addr 2 holds 0xABCD; write 0x1234 with `wea`=2'b01 → subsequent read returns 0xAB34; a same-cycle write-first read also returns 0xAB34.
- Reset mid-clear: assert `resetn` low at clear cycle 9 for one cycle → `ready` rises 16 cycles after release; all addresses read 0.
- Port A no-change: read addr 1 (0x055), then write addr 4 → `douta` holds 0x055 through the write cycle's output slot.

Source files
------------

// File: rtl/xilinx_bram_pkg.sv
// Shared definitions for the multi-port block RAM: address-width helper,
// collision-mode encodings and clear-FSM state encoding.
// No logic of its own; imported by every file of the RAM.
package xilinx_bram_pkg;

    // Collision mode of a read port (one bit per port in COLLIDE_WF)
    localparam logic RD_FIRST = 1'b0;
    localparam logic WR_FIRST = 1'b1;

    // Clear engine states
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Bits needed to represent 'value'; never less than 1 so a
    // single-entry array still has a one-bit address.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        for (r = 0; v > 0; r++) begin
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_clear_fsm.sv
// Post-reset clear engine: walks every address once, writing zero, then opens the RAM.
// Latency: ready rises RAM_DEPTH cycles after reset release (immediately if clearing is off).
// Backpressure: while clearing, ready=0 and the top level ignores all user requests.
module bram_clear_fsm
    import xilinx_bram_pkg::*;
#(
    parameter int RAM_DEPTH      = 1024,
    parameter int AW             = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clock,
    input  logic          resetn,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;

    // Sweep the address counter once per reset, then park in READY
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            if (clr_cnt == LAST_ADDR) begin
                state   <= ST_READY;
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    assign ready    = (state == ST_READY);
    // No array writes at all while reset is held: contents survive reset
    // until the sweep actually starts.
    assign clr_we   = (state == ST_CLEAR) && resetn;
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/xilinx_multi_port_bram.sv
// One byte-enabled read/write port plus NUM_RD read-only ports over a shared array,
// with per-port read-first/write-first collision handling and zero-fill after reset.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1); full throughput; ready=0 drops requests.
module xilinx_multi_port_bram
    import xilinx_bram_pkg::*;
#(
    parameter int                RAM_WIDTH      = 18,
    parameter int                RAM_DEPTH      = 1024,
    parameter int                BYTE_WIDTH     = RAM_WIDTH,
    parameter int                NUM_RD         = 2,
    parameter logic [NUM_RD-1:0] COLLIDE_WF     = '0,
    parameter bit                OUT_REG        = 1'b1,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    localparam int               AW             = clogb2(RAM_DEPTH - 1),
    localparam int               NB             = RAM_WIDTH / BYTE_WIDTH
) (
    input  logic                        clock,
    input  logic                        resetn,
    output logic                        ready,
    input  logic                        ena,
    input  logic [NB-1:0]               wea,
    input  logic [AW-1:0]               addra,
    input  logic [RAM_WIDTH-1:0]        dina,
    output logic [RAM_WIDTH-1:0]        douta,
    input  logic [NUM_RD-1:0]           enb,
    input  logic [NUM_RD*AW-1:0]        addrb,
    output logic [NUM_RD*RAM_WIDTH-1:0] doutb,
    output logic [NUM_RD-1:0]           validb
);

    // Parameter sanity: refuse to elaborate a configuration that cannot work
    if ((RAM_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
        $error("RAM_WIDTH must be a whole multiple of BYTE_WIDTH");
    end
    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
        $error("NUM_RD must be between 1 and 4");
    end

    // ------------------------------------------------------------------
    // Clear engine and write-port arbitration
    // ------------------------------------------------------------------
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    bram_clear_fsm #(
        .RAM_DEPTH      (RAM_DEPTH),
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clock    (clock),
        .resetn   (resetn),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic                 user_wr;
    logic                 user_rd_a;
    logic                 wr_en;
    logic [NB-1:0]        wr_be;
    logic [AW-1:0]        wr_addr;
    logic [RAM_WIDTH-1:0] wr_dat;

    // A user write only counts once the array is open and reset is released
    assign user_wr   = ready && resetn && ena && (wea != '0);
    assign user_rd_a = ready && ena && (wea == '0);

    // The clear engine owns the write port until ready; afterwards port A does
    always_comb begin
        wr_en   = clr_we;
        wr_be   = '1;
        wr_addr = clr_addr;
        wr_dat  = '0;
        if (ready) begin
            wr_en   = user_wr;
            wr_be   = wea;
            wr_addr = addra;
            wr_dat  = dina;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Byte-granular write; the array itself is never reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_dat[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Port A read register (no-change on write cycles)
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] a_q;

    // Capture only on pure reads so the last read word persists across writes
    always_ff @(posedge clock) begin
        if (!resetn) begin
            a_q <= '0;
        end else if (user_rd_a) begin
            a_q <= mem[addra];
        end
    end

    // ------------------------------------------------------------------
    // Read-only ports
    // ------------------------------------------------------------------
    logic [NUM_RD*RAM_WIDTH-1:0] rd_dat;
    logic [NUM_RD-1:0]           rd_vld;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]        addr_i;
        logic [RAM_WIDTH-1:0] raw;
        logic [RAM_WIDTH-1:0] nxt;
        logic [RAM_WIDTH-1:0] rd_q;
        logic                 vld_q;

        assign addr_i = addrb[i*AW +: AW];
        assign raw    = mem[addr_i];

        if (COLLIDE_WF[i] == RD_FIRST) begin : g_rf
            // Array still holds the pre-write word this cycle
            assign nxt = raw;
        end else begin : g_wf
            logic hit;
            assign hit = user_wr && (addra == addr_i);
            // Bypass only the bytes being written; untouched bytes come from the array
            for (genvar k = 0; k < NB; k++) begin : g_byte
                assign nxt[k*BYTE_WIDTH +: BYTE_WIDTH] = (hit && wea[k])
                    ? dina[k*BYTE_WIDTH +: BYTE_WIDTH]
                    : raw[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end

        // Data holds when idle; the valid flag tracks every cycle
        always_ff @(posedge clock) begin
            if (!resetn) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= ready && enb[i];
                if (ready && enb[i]) begin
                    rd_q <= nxt;
                end
            end
        end

        assign rd_dat[i*RAM_WIDTH +: RAM_WIDTH] = rd_q;
        assign rd_vld[i]                        = vld_q;
    end

    // ------------------------------------------------------------------
    // Optional output register stage, common to all read paths
    // ------------------------------------------------------------------
    if (OUT_REG) begin : g_oreg
        // Extra pipeline stage; reset flushes whatever is in flight
        always_ff @(posedge clock) begin
            if (!resetn) begin
                douta  <= '0;
                doutb  <= '0;
                validb <= '0;
            end else begin
                douta  <= a_q;
                doutb  <= rd_dat;
                validb <= rd_vld;
            end
        end
    end else begin : g_noreg
        assign douta  = a_q;
        assign doutb  = rd_dat;
        assign validb = rd_vld;
    end

endmodule

// File: tb/tb_xilinx_multi_port_bram.sv
// Scoreboard bench for xilinx_multi_port_bram: 16x16 array, 8-bit bytes,
// port B0 read-first, B1 write-first, output register on.
module tb_xilinx_multi_port_bram;

    localparam int LAT = 2;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        ready;
    logic        ena;
    logic [1:0]  wea;
    logic [3:0]  addra;
    logic [15:0] dina;
    logic [15:0] douta;
    logic [1:0]  enb;
    logic [7:0]  addrb;
    logic [31:0] doutb;
    logic [1:0]  validb;

    xilinx_multi_port_bram #(
        .RAM_WIDTH      (16),
        .RAM_DEPTH      (16),
        .BYTE_WIDTH     (8),
        .NUM_RD         (2),
        .COLLIDE_WF     (2'b10),
        .OUT_REG        (1'b1),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .ready  (ready),
        .ena    (ena),
        .wea    (wea),
        .addra  (addra),
        .dina   (dina),
        .douta  (douta),
        .enb    (enb),
        .addrb  (addrb),
        .doutb  (doutb),
        .validb (validb)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;

    exp_t qa[$];
    exp_t qb0[$];
    exp_t qb1[$];
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        ena   = 1'b0;
        wea   = 2'b00;
        addra = 4'd0;
        dina  = 16'd0;
        enb   = 2'b00;
        addrb = 8'd0;
    endtask

    // Present one cycle of stimulus on every port
    task automatic op(input logic a_en, input logic [1:0] a_we, input logic [3:0] a_ad,
                      input logic [15:0] a_d, input logic [1:0] b_en,
                      input logic [3:0] b0, input logic [3:0] b1);
        ena   = a_en;
        wea   = a_we;
        addra = a_ad;
        dina  = a_d;
        enb   = b_en;
        addrb = {b1, b0};
        tick();
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        op(1'b1, 2'b11, a, d, 2'b00, 4'd0, 4'd0);
    endtask

    // Expectations are pushed just before the request cycle they belong to
    task automatic exp_a(input logic [15:0] v);
        qa.push_back('{cyc + LAT, v});
    endtask

    task automatic exp_b(input int p, input logic [15:0] v);
        if (p == 0) qb0.push_back('{cyc + LAT, v});
        else        qb1.push_back('{cyc + LAT, v});
    endtask

    // Count cycles from reset release until ready; clear takes 16 cycles
    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!ready && n < 64) begin
            tick();
            n++;
        end
        chk(nm, n, 16);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations
    always @(negedge clock) begin
        if (validb[0]) begin
            if (qb0.size() == 0) begin
                chk("b0 unexpected validb", 32'(validb[0]), 32'd0);
            end else begin
                e = qb0.pop_front();
                chk("b0 latency", cyc, e.due);
                chk("b0 data", 32'(doutb[15:0]), 32'(e.dat));
            end
        end else if (qb0.size() > 0 && qb0[0].due <= cyc) begin
            e = qb0.pop_front();
            chk("b0 missing validb", 32'(validb[0]), 32'd1);
        end

        if (validb[1]) begin
            if (qb1.size() == 0) begin
                chk("b1 unexpected validb", 32'(validb[1]), 32'd0);
            end else begin
                e = qb1.pop_front();
                chk("b1 latency", cyc, e.due);
                chk("b1 data", 32'(doutb[31:16]), 32'(e.dat));
            end
        end else if (qb1.size() > 0 && qb1[0].due <= cyc) begin
            e = qb1.pop_front();
            chk("b1 missing validb", 32'(validb[1]), 32'd1);
        end

        if (qa.size() > 0 && qa[0].due <= cyc) begin
            e = qa.pop_front();
            chk("douta", 32'(douta), 32'(e.dat));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_in();
        resetn = 1'b0;
        repeat (3) tick();
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset validb", 32'(validb), 32'd0);
        chk("reset doutb", doutb, 32'd0);
        chk("reset douta", 32'(douta), 32'd0);

        resetn = 1'b1;
        wait_ready("ready after first clear");

        // Fill with ones, then reset: the sweep must zero it again
        for (int a = 0; a < 16; a++) wr(4'(a), 16'hFFFF);
        exp_b(0, 16'hFFFF);
        op(1'b0, 2'b00, 4'd0, 16'd0, 2'b01, 4'd5, 4'd0);
        clr_in();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        wait_ready("ready after reset over preloaded array");
        exp_b(0, 16'h0000);
        exp_b(1, 16'h0000);
        exp_a(16'h0000);
        op(1'b1, 2'b00, 4'd5, 16'd0, 2'b11, 4'd5, 4'd5);

        // Write then read next cycle
        wr(4'd3, 16'h02A5);
        exp_b(0, 16'h02A5);
        exp_a(16'h02A5);
        op(1'b1, 2'b00, 4'd3, 16'd0, 2'b01, 4'd3, 4'd0);

        // Collision: B0 read-first, B1 write-first
        wr(4'd7, 16'h0111);
        exp_b(0, 16'h0111);
        exp_b(1, 16'h0222);
        op(1'b1, 2'b11, 4'd7, 16'h0222, 2'b11, 4'd7, 4'd7);
        exp_b(0, 16'h0222);
        exp_b(1, 16'h0222);
        op(1'b0, 2'b00, 4'd0, 16'd0, 2'b11, 4'd7, 4'd7);

        // Byte enables, low byte then high byte, each with a colliding read
        wr(4'd2, 16'hABCD);
        exp_b(0, 16'hABCD);
        exp_b(1, 16'hAB34);
        op(1'b1, 2'b01, 4'd2, 16'h1234, 2'b11, 4'd2, 4'd2);
        exp_a(16'hAB34);
        exp_b(0, 16'hAB34);
        op(1'b1, 2'b00, 4'd2, 16'd0, 2'b01, 4'd2, 4'd0);
        exp_b(0, 16'hAB34);
        exp_b(1, 16'h5634);
        op(1'b1, 2'b10, 4'd2, 16'h5600, 2'b11, 4'd2, 4'd2);
        exp_a(16'h5634);
        op(1'b1, 2'b00, 4'd2, 16'd0, 2'b00, 4'd0, 4'd0);

        // Port A no-change across a write
        wr(4'd1, 16'h0055);
        exp_a(16'h0055);
        op(1'b1, 2'b00, 4'd1, 16'd0, 2'b00, 4'd0, 4'd0);
        exp_a(16'h0055);
        op(1'b1, 2'b11, 4'd4, 16'h0777, 2'b00, 4'd0, 4'd0);
        exp_a(16'h0777);
        op(1'b1, 2'b00, 4'd4, 16'd0, 2'b00, 4'd0, 4'd0);

        // Back-to-back reads on both B ports
        exp_b(0, 16'h0055); exp_b(1, 16'h0777);
        op(1'b0, 2'b00, 4'd0, 16'd0, 2'b11, 4'd1, 4'd4);
        exp_b(0, 16'h5634); exp_b(1, 16'h02A5);
        op(1'b0, 2'b00, 4'd0, 16'd0, 2'b11, 4'd2, 4'd3);
        exp_b(0, 16'h02A5); exp_b(1, 16'h0055);
        op(1'b0, 2'b00, 4'd0, 16'd0, 2'b11, 4'd3, 4'd1);
        exp_b(0, 16'h0222); exp_b(1, 16'h0777);
        op(1'b0, 2'b00, 4'd0, 16'd0, 2'b11, 4'd7, 4'd4);
        clr_in();
        repeat (3) tick();
        chk("hold b0 while idle", 32'(doutb[15:0]), 32'h0222);
        chk("hold b1 while idle", 32'(doutb[31:16]), 32'h0777);
        chk("validb low while idle", 32'(validb), 32'd0);
        chk("hold douta while idle", 32'(douta), 32'h0777);

        // Reset while a read is in flight
        op(1'b1, 2'b00, 4'd4, 16'd0, 2'b11, 4'd1, 4'd2);
        clr_in();
        resetn = 1'b0;
        tick();
        chk("mid-read reset doutb", doutb, 32'd0);
        chk("mid-read reset validb", 32'(validb), 32'd0);
        chk("mid-read reset douta", 32'(douta), 32'd0);
        chk("mid-read reset ready", 32'(ready), 32'd0);

        // Requests during clear must be dropped
        resetn = 1'b1;
        ena    = 1'b1;
        wea    = 2'b11;
        addra  = 4'd0;
        dina   = 16'hFFFF;
        enb    = 2'b11;
        addrb  = {4'd1, 4'd2};
        wait_ready("ready with requests during clear");
        clr_in();
        exp_b(0, 16'h0000);
        exp_a(16'h0000);
        op(1'b1, 2'b00, 4'd0, 16'd0, 2'b01, 4'd0, 4'd0);

        // Reset in the middle of the clear sweep restarts it
        for (int a = 0; a < 16; a++) wr(4'(a), 16'hFFFF);
        clr_in();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (9) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        wait_ready("ready after reset mid-clear");
        for (int a = 0; a < 16; a++) begin
            exp_b(0, 16'h0000);
            exp_b(1, 16'h0000);
            exp_a(16'h0000);
            op(1'b1, 2'b00, 4'(a), 16'd0, 2'b11, 4'(a), 4'(15 - a));
        end
        clr_in();
        repeat (5) tick();

        chk("scoreboard drained", qa.size() + qb0.size() + qb1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
